// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage with a req/ready data-memory handshake, wait-state timeout,
// BEQ/BNE resolution and the MEM/WB register. Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_stage #(
   parameter int unsigned WAIT_LIMIT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] result,
   input  logic [31:0] writeData_MEM,
   input  logic [2:0]  func3_MEM,
   input  logic        isZero,
   input  logic [31:0] newPC_MEM,
   input  logic        MemToReg_MEM,
   input  logic        RegWrite_MEM,
   input  logic        MemRead_MEM,
   input  logic        MemWrite_MEM,
   input  logic        branch_op_MEM,
   input  logic [4:0]  rd_MEM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic        stall,
   output logic        pcSrc,
   output logic [31:0] branchTarget,
   output logic        bus_err,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic        misaligned,
`endif
   output logic [31:0] readData_WB,
   output logic [31:0] aluResult_WB,
   output logic [4:0]  rd_WB,
   output logic        RegWrite_WB,
   output logic        MemToReg_WB
);

   typedef enum logic {IDLE, WAIT} memStateT;
   localparam logic [7:0] LimitCnt = 8'(WAIT_LIMIT);

   memStateT    stateQ, stateD;
   logic [7:0]  cntQ, cntD;
   logic        memop, isByte, isHalf, misalignHit, reqOk, timeout, bubble;
   logic [1:0]  a;
   logic [7:0]  laneByte;
   logic [15:0] laneHalf;
   logic [31:0] loadData, storeData;
   logic [3:0]  storeBe;
   logic        busErrQ, regWriteQ, memToRegQ;
   logic [31:0] readDataQ, aluResultQ;
   logic [4:0]  rdQ;

   assign a      = result[1:0];
   assign memop  = MemRead_MEM | MemWrite_MEM;
   // Stores only know 000/001 as narrow widths; loads also accept the unsigned 100/101 encodings.
   assign isByte = MemWrite_MEM ? (func3_MEM == 3'b000) : (func3_MEM[1:0] == 2'b00);
   assign isHalf = MemWrite_MEM ? (func3_MEM == 3'b001) : (func3_MEM[1:0] == 2'b01);

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalignHit = memop && (stateQ == IDLE) && (isHalf ? a[0] : (!isByte && (a != 2'b00)));
`else
   assign misalignHit = 1'b0;
`endif
   assign reqOk = memop & ~misalignHit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateQ <= IDLE;
         cntQ   <= '0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
      end
   end

   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      case (stateQ)
         IDLE: begin
            if (reqOk && !dmem_ready) begin
               stateD = WAIT;
               cntD   = 8'd1;
            end else begin
               cntD   = '0;
            end
         end
         WAIT: begin
            if (dmem_ready || (cntQ == LimitCnt)) begin
               stateD = IDLE;
               cntD   = '0;
            end else begin
               cntD   = cntQ + 8'd1;
            end
         end
      endcase
   end

   // Request and stall are forced low while reset is held so an abandoned access is dropped at once.
   always_comb begin
      dmem_req = 1'b0;
      stall    = 1'b0;
      if (reset) begin
         case (stateQ)
            IDLE: begin
               dmem_req = reqOk;
               stall    = reqOk & ~dmem_ready;
            end
            WAIT: begin
               dmem_req = 1'b1;
               stall    = ~dmem_ready & (cntQ != LimitCnt);
            end
         endcase
      end
   end

   assign timeout = (stateQ == WAIT) & ~dmem_ready & (cntQ == LimitCnt);
   assign bubble  = stall | timeout | misalignHit;

   always_comb begin
      laneByte = dmem_rdata[{a, 3'b000} +: 8];
      laneHalf = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (func3_MEM)
         3'b000:  loadData = {{24{laneByte[7]}}, laneByte};
         3'b001:  loadData = {{16{laneHalf[15]}}, laneHalf};
         3'b100:  loadData = {24'd0, laneByte};
         3'b101:  loadData = {16'd0, laneHalf};
         default: loadData = dmem_rdata;
      endcase
      if (isByte) begin
         storeBe   = 4'b0001 << a;
         storeData = {4{writeData_MEM[7:0]}};
      end else if (isHalf) begin
         storeBe   = a[1] ? 4'b1100 : 4'b0011;
         storeData = {2{writeData_MEM[15:0]}};
      end else begin
         storeBe   = 4'b1111;
         storeData = writeData_MEM;
      end
   end

   assign dmem_addr    = {result[31:2], 2'b00};
   assign dmem_we      = dmem_req & MemWrite_MEM;
   assign dmem_be      = MemWrite_MEM ? storeBe : 4'b1111;
   assign dmem_wdata   = storeData;
   assign pcSrc        = branch_op_MEM & (((func3_MEM == 3'b000) & isZero) | ((func3_MEM == 3'b001) & ~isZero));
   assign branchTarget = newPC_MEM;

   // A stalled, timed-out or trapped instruction retires as a bubble; data registers keep their value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busErrQ    <= 1'b0;
         regWriteQ  <= 1'b0;
         memToRegQ  <= 1'b0;
         rdQ        <= '0;
         readDataQ  <= '0;
         aluResultQ <= '0;
      end else begin
         busErrQ <= timeout;
         if (bubble) begin
            regWriteQ <= 1'b0;
            memToRegQ <= 1'b0;
            rdQ       <= '0;
         end else begin
            regWriteQ  <= RegWrite_MEM;
            memToRegQ  <= MemToReg_MEM;
            rdQ        <= rd_MEM;
            readDataQ  <= loadData;
            aluResultQ <= result;
         end
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   logic misalignedQ;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) misalignedQ <= 1'b0;
      else        misalignedQ <= misalignHit;
   end
   assign misaligned = misalignedQ;
`endif

   assign bus_err      = busErrQ;
   assign RegWrite_WB  = regWriteQ;
   assign MemToReg_WB  = memToRegQ;
   assign rd_WB        = rdQ;
   assign readData_WB  = readDataQ;
   assign aluResult_WB = aluResultQ;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a lane/extension/latency model
// derived from the stage's behavioural rules.
module tb_mem_stage;
   localparam int WaitLimit = 15;
   localparam int MaxCycles = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] result, writeData_MEM, newPC_MEM, dmem_rdata;
   logic [2:0]  func3_MEM;
   logic        isZero, MemToReg_MEM, RegWrite_MEM, MemRead_MEM, MemWrite_MEM, branch_op_MEM, dmem_ready;
   logic [4:0]  rd_MEM;
   logic        dmem_req, dmem_we, stall, pcSrc, bus_err, RegWrite_WB, MemToReg_WB;
   logic [31:0] dmem_addr, dmem_wdata, branchTarget, readData_WB, aluResult_WB;
   logic [3:0]  dmem_be;
   logic [4:0]  rd_WB;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misaligned;
`endif

   int          checks = 0;
   int          fails = 0;
   int          obsStall;
   logic        obsReqOk, obsWe;
   logic [3:0]  obsBe;
   logic [31:0] obsWdata, obsAddr;

   mem_stage #(.WAIT_LIMIT(WaitLimit)) dut (
      .clk(clk), .reset(reset), .result(result), .writeData_MEM(writeData_MEM), .func3_MEM(func3_MEM),
      .isZero(isZero), .newPC_MEM(newPC_MEM), .MemToReg_MEM(MemToReg_MEM), .RegWrite_MEM(RegWrite_MEM),
      .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .branch_op_MEM(branch_op_MEM), .rd_MEM(rd_MEM),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .stall(stall), .pcSrc(pcSrc),
      .branchTarget(branchTarget), .bus_err(bus_err),
`ifdef MEM_MISALIGN_TRAP_EN
      .misaligned(misaligned),
`endif
      .readData_WB(readData_WB), .aluResult_WB(aluResult_WB), .rd_WB(rd_WB),
      .RegWrite_WB(RegWrite_WB), .MemToReg_WB(MemToReg_WB)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [3:0] modelBe(input logic [2:0] f3, input int a, input logic wr);
      if (!wr) return 4'hF;
      if (f3 == 3'd0) return 4'(1 << a);
      if (f3 == 3'd1) return 4'(3 << ((a / 2) * 2));
      return 4'hF;
   endfunction

   function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] wd);
      if (f3 == 3'd0) return 32'(wd % 256) * 32'h0101_0101;
      if (f3 == 3'd1) return 32'(wd % 65536) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] modelLoad(input logic [2:0] f3, input int a, input logic [31:0] rdata);
      int unsigned byteVal, halfVal;
      byteVal = (rdata >> (8 * a)) % 256;
      halfVal = (rdata >> (16 * (a / 2))) % 65536;
      case (f3)
         3'd0:    return (byteVal >= 128) ? byteVal - 256 : byteVal;
         3'd1:    return (halfVal >= 32768) ? halfVal - 65536 : halfVal;
         3'd4:    return byteVal;
         3'd5:    return halfVal;
         default: return rdata;
      endcase
   endfunction

   // Drives one instruction, answers with ready after readyDelay cycles, returns just after its retiring edge.
   task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] res, input logic [31:0] wd,
                                input logic rdEn, input logic wrEn, input logic m2r, input logic rw,
                                input logic [4:0] rd, input int readyDelay, input logic [31:0] rdata);
      bit done;
      func3_MEM = f3; result = res; writeData_MEM = wd; MemRead_MEM = rdEn; MemWrite_MEM = wrEn;
      MemToReg_MEM = m2r; RegWrite_MEM = rw; rd_MEM = rd; dmem_rdata = rdata;
      obsStall = 0; obsReqOk = 1'b1; done = 1'b0;
      for (int k = 0; k < MaxCycles && !done; k++) begin
         dmem_ready = (k == readyDelay);
         #1;
         if (k == 0) begin
            obsBe = dmem_be; obsWdata = dmem_wdata; obsAddr = dmem_addr; obsWe = dmem_we;
         end
         if (dmem_req !== (rdEn | wrEn)) obsReqOk = 1'b0;
         if (stall === 1'b1) obsStall++;
         else done = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (!done) begin
         fails++;
         $display("[TB] FAIL access_bound: stall still high after %0d cycles, required release", MaxCycles);
      end
      MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; result = '0; writeData_MEM = '0; func3_MEM = '0; isZero = 1'b0; newPC_MEM = '0;
      MemToReg_MEM = 1'b0; RegWrite_MEM = 1'b0; MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0;
      branch_op_MEM = 1'b0; rd_MEM = '0; dmem_rdata = '0; dmem_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks += 4;
      if (RegWrite_WB !== 1'b0 || MemToReg_WB !== 1'b0) begin
         fails++; $display("[TB] FAIL reset_ctrl: got %b%b required 00", RegWrite_WB, MemToReg_WB);
      end
      if (rd_WB !== 5'd0) begin fails++; $display("[TB] FAIL reset_rd: got %h required 0", rd_WB); end
      if (readData_WB !== 32'd0 || aluResult_WB !== 32'd0) begin
         fails++; $display("[TB] FAIL reset_data: got %h/%h required 0/0", readData_WB, aluResult_WB);
      end
      if (bus_err !== 1'b0 || stall !== 1'b0) begin
         fails++; $display("[TB] FAIL reset_flags: bus_err %b stall %b required 0 0", bus_err, stall);
      end
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_store_word();
      applyStimulus(3'b010, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 0, 32'h0);
      checks += 4;
      if (obsReqOk !== 1'b1 || obsWe !== 1'b1) begin
         fails++; $display("[TB] FAIL sw_req: req_ok %b we %b required 1 1", obsReqOk, obsWe);
      end
      if (obsAddr !== 32'h100 || obsBe !== 4'hF) begin
         fails++; $display("[TB] FAIL sw_lane: addr %h be %b required 100 1111", obsAddr, obsBe);
      end
      if (obsWdata !== 32'hDEAD_BEEF || obsStall != 0) begin
         fails++; $display("[TB] FAIL sw_data: wdata %h stall %0d required deadbeef 0", obsWdata, obsStall);
      end
      if (RegWrite_WB !== 1'b0) begin fails++; $display("[TB] FAIL sw_regwrite: got %b required 0", RegWrite_WB); end
   endtask

   task automatic test_load_wait();
      applyStimulus(3'b000, 32'h203, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 3, 32'h80FF_FFFF);
      checks += 4;
      if (obsStall != 3) begin fails++; $display("[TB] FAIL lb_stall: got %0d cycles required 3", obsStall); end
      if (readData_WB !== 32'hFFFF_FF80) begin
         fails++; $display("[TB] FAIL lb_data: got %h required ffffff80", readData_WB);
      end
      if (MemToReg_WB !== 1'b1 || rd_WB !== 5'd5) begin
         fails++; $display("[TB] FAIL lb_ctrl: m2r %b rd %0d required 1 5", MemToReg_WB, rd_WB);
      end
      if (obsAddr !== 32'h200 || obsBe !== 4'hF || obsWe !== 1'b0) begin
         fails++; $display("[TB] FAIL lb_bus: addr %h be %b we %b required 200 1111 0", obsAddr, obsBe, obsWe);
      end
      applyStimulus(3'b100, 32'h203, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 3, 32'h80FF_FFFF);
      checks++;
      if (readData_WB !== 32'h0000_0080) begin
         fails++; $display("[TB] FAIL lbu_data: got %h required 00000080", readData_WB);
      end
   endtask

   task automatic test_store_half();
      applyStimulus(3'b001, 32'h42, 32'h1234_ABCD, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1, 32'h0);
      checks += 2;
      if (obsBe !== 4'b1100 || obsAddr !== 32'h40) begin
         fails++; $display("[TB] FAIL sh_lane: be %b addr %h required 1100 40", obsBe, obsAddr);
      end
      if (obsWdata !== 32'hABCD_ABCD || obsStall != 1) begin
         fails++; $display("[TB] FAIL sh_data: wdata %h stall %0d required abcdabcd 1", obsWdata, obsStall);
      end
   endtask

   task automatic test_timeout();
      applyStimulus(3'b000, 32'h5A5A_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 0, 32'h0);
      checks++;
      if (aluResult_WB !== 32'h5A5A_0000 || RegWrite_WB !== 1'b1) begin
         fails++; $display("[TB] FAIL alu_pass: got %h/%b required 5a5a0000/1", aluResult_WB, RegWrite_WB);
      end
      applyStimulus(3'b010, 32'h40, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 999, 32'h1234_5678);
      checks += 4;
      if (obsStall != WaitLimit) begin
         fails++; $display("[TB] FAIL to_stall: got %0d cycles required %0d", obsStall, WaitLimit);
      end
      if (bus_err !== 1'b1) begin fails++; $display("[TB] FAIL to_buserr: got %b required 1", bus_err); end
      if (RegWrite_WB !== 1'b0 || rd_WB !== 5'd0) begin
         fails++; $display("[TB] FAIL to_bubble: regwrite %b rd %0d required 0 0", RegWrite_WB, rd_WB);
      end
      if (aluResult_WB !== 32'h5A5A_0000) begin
         fails++; $display("[TB] FAIL to_hold: got %h required 5a5a0000", aluResult_WB);
      end
      @(posedge clk); #1;
      checks++;
      if (bus_err !== 1'b0 || stall !== 1'b0 || dmem_req !== 1'b0) begin
         fails++; $display("[TB] FAIL to_idle: bus_err %b stall %b req %b required 0 0 0", bus_err, stall, dmem_req);
      end
   endtask

   task automatic test_branch();
      logic expTaken;
      logic [2:0] f3;
      branch_op_MEM = 1'b1; func3_MEM = 3'b001; isZero = 1'b0; newPC_MEM = 32'h80;
      #1;
      checks++;
      if (pcSrc !== 1'b1 || branchTarget !== 32'h80) begin
         fails++; $display("[TB] FAIL bne_taken: pcSrc %b target %h required 1 80", pcSrc, branchTarget);
      end
      isZero = 1'b1;
      #1;
      checks++;
      if (pcSrc !== 1'b0) begin fails++; $display("[TB] FAIL bne_not_taken: got %b required 0", pcSrc); end
      for (int i = 0; i < 16; i++) begin
         f3 = 3'($urandom_range(0, 3));
         branch_op_MEM = 1'($urandom_range(0, 1)); isZero = 1'($urandom_range(0, 1));
         func3_MEM = f3; newPC_MEM = $urandom;
         expTaken = branch_op_MEM && ((f3 == 3'd0 && isZero) || (f3 == 3'd1 && !isZero));
         #1;
         checks++;
         if (pcSrc !== expTaken || branchTarget !== newPC_MEM) begin
            fails++; $display("[TB] FAIL branch_rand: pcSrc %b required %b (op %b f3 %0d z %b)",
                              pcSrc, expTaken, branch_op_MEM, f3, isZero);
         end
      end
      branch_op_MEM = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int kind, delay, a, expStall;
      logic rdEn, wrEn, m2r, rw, expTo;
      logic [2:0] f3;
      logic [4:0] rd;
      logic [31:0] res, wd, rdata;
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 3);
         f3 = 3'($urandom_range(0, 7));
         res = $urandom; wd = $urandom; rdata = $urandom; rd = 5'($urandom_range(1, 31));
         delay = ($urandom_range(0, 9) == 0) ? 999 : $urandom_range(0, 4);
         rdEn = (kind == 1) || (kind == 3);
         wrEn = (kind >= 2);
         m2r = rdEn && !wrEn;
         rw = wrEn ? 1'b0 : 1'($urandom_range(0, 1));
         a = res % 4;
         expStall = (rdEn || wrEn) ? ((delay < WaitLimit) ? delay : WaitLimit) : 0;
         expTo = (rdEn || wrEn) && (delay > WaitLimit);
         applyStimulus(f3, res, wd, rdEn, wrEn, m2r, rw, rd, delay, rdata);
         checks += 4;
         if (obsStall != expStall || obsReqOk !== 1'b1) begin
            fails++; $display("[TB] FAIL rand_handshake[%0d]: stall %0d req_ok %b required %0d 1",
                              i, obsStall, obsReqOk, expStall);
         end
         if (bus_err !== expTo) begin
            fails++; $display("[TB] FAIL rand_buserr[%0d]: got %b required %b", i, bus_err, expTo);
         end
         if (RegWrite_WB !== (rw && !expTo) || MemToReg_WB !== (m2r && !expTo) || rd_WB !== (expTo ? 5'd0 : rd)) begin
            fails++; $display("[TB] FAIL rand_ctrl[%0d]: rw %b m2r %b rd %0d required %b %b %0d", i,
                              RegWrite_WB, MemToReg_WB, rd_WB, rw && !expTo, m2r && !expTo, expTo ? 5'd0 : rd);
         end
         if (obsAddr !== {res[31:2], 2'b00} || obsWe !== wrEn) begin
            fails++; $display("[TB] FAIL rand_addr[%0d]: addr %h we %b required %h %b", i, obsAddr, obsWe,
                              {res[31:2], 2'b00}, wrEn);
         end
         if (rdEn || wrEn) begin
            checks++;
            if (obsBe !== modelBe(f3, a, wrEn)) begin
               fails++; $display("[TB] FAIL rand_be[%0d]: got %b required %b", i, obsBe, modelBe(f3, a, wrEn));
            end
         end
         if (wrEn) begin
            checks++;
            if (obsWdata !== modelWdata(f3, wd)) begin
               fails++; $display("[TB] FAIL rand_wdata[%0d]: got %h required %h", i, obsWdata, modelWdata(f3, wd));
            end
         end
         if (!expTo) begin
            checks++;
            if (aluResult_WB !== res) begin
               fails++; $display("[TB] FAIL rand_alu[%0d]: got %h required %h", i, aluResult_WB, res);
            end
         end
         if (m2r && !expTo) begin
            checks++;
            if (readData_WB !== modelLoad(f3, a, rdata)) begin
               fails++; $display("[TB] FAIL rand_load[%0d]: got %h required %h", i, readData_WB, modelLoad(f3, a, rdata));
            end
         end
      end
   endtask

   task automatic test_reset_mid_access();
      applyStimulus(3'b010, 32'h444, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 0, 32'hCAFE_F00D);
      checks++;
      if (rd_WB !== 5'd9 || readData_WB !== 32'hCAFE_F00D) begin
         fails++; $display("[TB] FAIL pre_reset_load: rd %0d data %h required 9 cafef00d", rd_WB, readData_WB);
      end
      func3_MEM = 3'b010; result = 32'h300; MemRead_MEM = 1'b1; RegWrite_MEM = 1'b1; MemToReg_MEM = 1'b1;
      rd_MEM = 5'd7; dmem_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (stall !== 1'b1 || dmem_req !== 1'b1) begin
         fails++; $display("[TB] FAIL wait_before_reset: stall %b req %b required 1 1", stall, dmem_req);
      end
      #1 reset = 1'b0;
      #1;
      checks += 3;
      if (dmem_req !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_req: got %b required 0", dmem_req); end
      if (RegWrite_WB !== 1'b0 || MemToReg_WB !== 1'b0 || rd_WB !== 5'd0) begin
         fails++; $display("[TB] FAIL mid_reset_ctrl: %b %b %0d required 0 0 0", RegWrite_WB, MemToReg_WB, rd_WB);
      end
      if (readData_WB !== 32'd0 || aluResult_WB !== 32'd0) begin
         fails++; $display("[TB] FAIL mid_reset_data: %h %h required 0 0", readData_WB, aluResult_WB);
      end
      MemRead_MEM = 1'b0; RegWrite_MEM = 1'b0; MemToReg_MEM = 1'b0;
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (stall !== 1'b0 || dmem_req !== 1'b0) begin
         fails++; $display("[TB] FAIL post_reset_idle: stall %b req %b required 0 0", stall, dmem_req);
      end
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_load_wait();
      test_store_half();
      test_branch();
      test_timeout();
      test_random();
      test_reset_mid_access();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
